// File: rtl/rv32i_alu_decode.sv
// RV32I ALU decode stage with a 2-entry skid buffer on the output.
// Define RV32I_DEC_ILLEGAL_EN to flag illegal bundles and freeze on them.
module rv32i_alu_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  ALU_Ctrl,
  output logic [31:0] Imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        illegal
);

`ifdef RV32I_DEC_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        bad;
  } bun_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t      state;
  bun_t        out_q;
  bun_t        skid_q;
  bun_t        dec;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7z;
  logic        f7a;
  logic        is_r;
  logic        is_i;
  logic [4:0]  c;
  logic [1:0]  ik;
  logic        bad;
  logic [31:0] imm;
  logic        hold;
  logic        acc;
  logic        drn;

  assign op   = in_inst[6:0];
  assign f3   = in_inst[14:12];
  assign f7   = in_inst[31:25];
  assign f7z  = f7 == 7'b0000000;
  assign f7a  = f7 == 7'b0100000;
  assign is_r = op == 7'b0110011;
  assign is_i = op == 7'b0010011;

  // ik: 0 no immediate, 1 sign-extended imm12, 2 zero-extended shamt
  always_comb begin
    c  = 5'd0;
    ik = 2'd0;
    unique case (1'b1)
      is_r: begin
        unique case (f3)
          3'd0: c = f7z ? 5'd1 : (f7a ? 5'd9 : 5'd0);
          3'd1: c = f7z ? 5'd17 : 5'd0;
          3'd2: c = f7z ? 5'd10 : 5'd0;
          3'd3: c = f7z ? 5'd12 : 5'd0;
          3'd4: c = f7z ? 5'd5 : 5'd0;
          3'd5: c = f7z ? 5'd18 : (f7a ? 5'd19 : 5'd0);
          3'd6: c = f7z ? 5'd3 : 5'd0;
          3'd7: c = f7z ? 5'd7 : 5'd0;
        endcase
      end
      is_i: begin
        ik = 2'd1;
        unique case (f3)
          3'd0: c = 5'd2;
          3'd1: begin
            c  = f7z ? 5'd14 : 5'd0;
            ik = 2'd2;
          end
          3'd2: c = 5'd11;
          3'd3: c = 5'd13;
          3'd4: c = 5'd6;
          3'd5: begin
            c  = f7z ? 5'd15 : (f7a ? 5'd16 : 5'd0);
            ik = 2'd2;
          end
          3'd6: c = 5'd4;
          3'd7: c = 5'd8;
        endcase
      end
      default: c = 5'd0;
    endcase
  end

  assign bad = c == 5'd0;

  always_comb begin
    imm = 32'd0;
    if (!bad) begin
      unique case (ik)
        2'd1:    imm = {{20{in_inst[31]}}, in_inst[31:20]};
        2'd2:    imm = {27'd0, in_inst[24:20]};
        default: imm = 32'd0;
      endcase
    end
  end

  assign dec = '{
    ctrl: c,
    imm:  imm,
    rs1:  in_inst[19:15],
    rs2:  in_inst[24:20],
    rd:   in_inst[11:7],
    bad:  bad & ILL_EN
  };

  // An illegal bundle at the head stalls both sides until reset.
  assign hold      = out_valid & out_q.bad;
  assign out_valid = state != EMPTY;
  assign in_ready  = (state != TWO) & ~hold;
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready & ~hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            out_q <= dec;
            state <= ONE;
          end
        end
        ONE: begin
          if (acc && !drn) begin
            skid_q <= dec;
            state  <= TWO;
          end else if (drn && !acc) begin
            state <= EMPTY;
          end else if (acc) begin
            out_q <= dec;
          end
        end
        TWO: begin
          if (drn) begin
            out_q <= skid_q;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign ALU_Ctrl = out_q.ctrl;
  assign Imm      = out_q.imm;
  assign rs1      = out_q.rs1;
  assign rs2      = out_q.rs2;
  assign rd       = out_q.rd;
  assign illegal  = out_q.bad;

endmodule
